// File: rtl/can_arb_sequencer.sv
// CAN transmit arbitration sequencer: drives SOF, ID and RTR with bit
// stuffing and reports won, lost or bit error from the sampled bus.
module can_arb_sequencer #(
  parameter int ID_W      = 11,
  parameter int STUFF_LEN = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_point,
  input  logic            sample_point,
  input  logic            sampled_rx,
  input  logic            bus_idle,
  input  logic            start,
  input  logic            abort,
  input  logic [ID_W-1:0] id,
  input  logic            rtr,
  output logic            tx,
  output logic            busy,
  output logic            won,
  output logic            lost,
  output logic            err
);

  localparam int FW = ID_W + 1;
  localparam int CW = $clog2(FW + 1);
  localparam int RW = $clog2(STUFF_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    RELEASE
  } state_t;

  typedef enum logic [1:0] {
    K_SOF,
    K_STUFF,
    K_FIELD
  } kind_t;

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [FW-1:0] sh_q, sh_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic          run_val_q, run_val_d;
  logic          tx_d, busy_d;
  logic          won_d, lost_d, err_d;
  logic          mismatch, on_last;
  logic          field_left, quit;
  logic          nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind_q    <= K_SOF;
      sh_q      <= '0;
      fcnt_q    <= '0;
      run_cnt_q <= '0;
      run_val_q <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      won       <= 1'b0;
      lost      <= 1'b0;
      err       <= 1'b0;
    end else begin
      kind_q    <= kind_d;
      sh_q      <= sh_d;
      fcnt_q    <= fcnt_d;
      run_cnt_q <= run_cnt_d;
      run_val_q <= run_val_d;
      tx        <= tx_d;
      busy      <= busy_d;
      won       <= won_d;
      lost      <= lost_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    sh_d       = sh_q;
    fcnt_d     = fcnt_q;
    run_cnt_d  = run_cnt_q;
    run_val_d  = run_val_q;
    tx_d       = tx;
    busy_d     = busy;
    won_d      = 1'b0;
    lost_d     = 1'b0;
    err_d      = 1'b0;
    quit       = 1'b0;
    nxt        = sh_q[FW-1];
    mismatch   = sampled_rx != tx;
    on_last    = (kind_q == K_FIELD) &&
                 (fcnt_q == CW'(FW));
    field_left = fcnt_q != CW'(FW);

    unique case (state_q)
      IDLE: begin
        if (start && bus_idle) begin
          sh_d      = {id, rtr};
          busy_d    = 1'b1;
          fcnt_d    = '0;
          run_cnt_d = '0;
          run_val_d = 1'b0;
          kind_d    = K_SOF;
          state_d   = ARM;
        end
      end
      ARM: begin
        if (abort) begin
          quit = 1'b1;
        end else if (tx_point) begin
          tx_d      = 1'b0;
          run_cnt_d = RW'(1);
          run_val_d = 1'b0;
          kind_d    = K_SOF;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          quit = 1'b1;
        end else if (sample_point && mismatch) begin
          quit = 1'b1;
          // recessive field bit overwritten: someone else wins
          if (kind_q == K_FIELD && tx) begin
            lost_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (sample_point && on_last) begin
          won_d   = 1'b1;
          state_d = RELEASE;
          quit    = tx_point;
        end else if (tx_point && field_left) begin
          if (run_cnt_q == RW'(STUFF_LEN)) begin
            tx_d      = ~run_val_q;
            run_cnt_d = RW'(1);
            run_val_d = ~run_val_q;
            kind_d    = K_STUFF;
          end else begin
            tx_d   = nxt;
            sh_d   = {sh_q[FW-2:0], 1'b0};
            fcnt_d = fcnt_q + CW'(1);
            kind_d = K_FIELD;
            if (nxt == run_val_q) begin
              run_cnt_d = run_cnt_q + RW'(1);
            end else begin
              run_cnt_d = RW'(1);
              run_val_d = nxt;
            end
          end
        end
      end
      RELEASE: begin
        quit = abort | tx_point;
      end
      default: begin
        quit = 1'b1;
      end
    endcase

    if (quit) begin
      tx_d    = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
    end
  end

endmodule

// File: tb/tb_can_arb_sequencer.sv
// Bench for can_arb_sequencer: a stuffed-bitstream model predicts tx,
// busy and the result pulses every cycle; literals pin the model.
module tb_can_arb_sequencer;

  localparam int ID_W = 11;

  logic            clk = 1'b0;
  logic            reset;
  logic            tx_point;
  logic            sample_point;
  logic            sampled_rx;
  logic            bus_idle;
  logic            start;
  logic            abort;
  logic [ID_W-1:0] id;
  logic            rtr;
  logic            tx;
  logic            busy;
  logic            won;
  logic            lost;
  logic            err;

  can_arb_sequencer #(
    .ID_W     (ID_W),
    .STUFF_LEN(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_point    (tx_point),
    .sample_point(sample_point),
    .sampled_rx  (sampled_rx),
    .bus_idle    (bus_idle),
    .start       (start),
    .abort       (abort),
    .id          (id),
    .rtr         (rtr),
    .tx          (tx),
    .busy        (busy),
    .won         (won),
    .lost        (lost),
    .err         (err)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   seq[$];
  int   kinds[$];
  bit   cap[$];
  bit   m_busy = 1'b0;
  bit   m_done = 1'b0;
  int   m_pos = 0;
  logic exp_tx = 1'b1;
  logic exp_busy = 1'b0;
  logic exp_won = 1'b0;
  logic exp_lost = 1'b0;
  logic exp_err = 1'b0;
  int   force_pos = -1;
  bit   force_val = 1'b0;
  int   won_seen = 0;
  int   lost_seen = 0;
  int   err_seen = 0;
  int   w0, l0, e0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("tx", 32'(tx), 32'(exp_tx));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("won", 32'(won), 32'(exp_won));
    chk("lost", 32'(lost), 32'(exp_lost));
    chk("err", 32'(err), 32'(exp_err));
    if (won) won_seen++;
    if (lost) lost_seen++;
    if (err) err_seen++;
  end

  // Stream = SOF, then field bits; a complement is inserted whenever
  // the last five bits on the wire are identical.
  function automatic void build(input logic [ID_W-1:0] i, input logic r);
    logic [ID_W:0] f;
    bit            same;
    f = {i, r};
    seq.delete();
    kinds.delete();
    seq.push_back(1'b0);
    kinds.push_back(0);
    for (int k = ID_W; k >= 0; k--) begin
      same = seq.size() >= 5;
      for (int j = 1; j <= 5 && same; j++)
        if (seq[seq.size()-j] != seq[seq.size()-1]) same = 1'b0;
      if (same) begin
        seq.push_back(~seq[seq.size()-1]);
        kinds.push_back(1);
      end
      seq.push_back(f[k]);
      kinds.push_back(2);
    end
  endfunction

  function automatic logic [31:0] pack_seq();
    logic [31:0] v = '0;
    foreach (seq[i]) v = {v[30:0], seq[i]};
    return v;
  endfunction

  function automatic logic [31:0] pack_cap(input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++)
      v = {v[30:0], (i < cap.size()) ? logic'(cap[i]) : 1'bx};
    return v;
  endfunction

  task automatic model_edge(input bit tp, input bit sp, input bit rx);
    bit stop;
    exp_won  = 1'b0;
    exp_lost = 1'b0;
    exp_err  = 1'b0;
    stop     = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
      exp_tx = 1'b1;
    end else if (!m_busy) begin
      if (start && bus_idle) begin
        build(id, rtr);
        m_busy = 1'b1;
        m_pos  = 0;
        m_done = 1'b0;
      end
    end else if (abort) begin
      m_busy = 1'b0;
      exp_tx = 1'b1;
    end else if (m_pos == 0) begin
      if (tp) begin
        exp_tx = seq[0];
        m_pos  = 1;
      end
    end else begin
      if (sp && !m_done) begin
        if (rx != seq[m_pos-1]) begin
          stop = 1'b1;
          if (kinds[m_pos-1] == 2 && seq[m_pos-1]) exp_lost = 1'b1;
          else exp_err = 1'b1;
        end else if (m_pos == seq.size()) begin
          m_done  = 1'b1;
          exp_won = 1'b1;
        end
      end
      if (stop || (tp && m_done)) begin
        m_busy = 1'b0;
        exp_tx = 1'b1;
      end else if (tp && m_pos < seq.size()) begin
        exp_tx = seq[m_pos];
        m_pos++;
      end
    end
    exp_busy = m_busy;
  endtask

  task automatic step(input bit tp, input bit sp);
    tx_point     = tp;
    sample_point = sp;
    if (m_busy && m_pos > 0 && (m_pos - 1) == force_pos)
      sampled_rx = force_val;
    else
      sampled_rx = exp_tx;
    @(posedge clk);
    model_edge(tp, sp, sampled_rx);
    #1;
    tx_point     = 1'b0;
    sample_point = 1'b0;
    if (tp) cap.push_back(tx);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic do_bit(input bit co);
    if (co) begin
      step(1'b1, 1'b1);
      idle(3);
    end else begin
      step(1'b1, 1'b0);
      idle(2);
      step(1'b0, 1'b1);
      idle(2);
    end
  endtask

  task automatic start_frame(input logic [ID_W-1:0] i, input logic r);
    id       = i;
    rtr      = r;
    bus_idle = 1'b1;
    start    = 1'b1;
    cap.delete();
    w0 = won_seen;
    l0 = lost_seen;
    e0 = err_seen;
    step(1'b0, 1'b0);
    start = 1'b0;
  endtask

  task automatic run_rest(input bit co);
    for (int b = 0; b < 40 && m_busy; b++) do_bit(co);
    idle(3);
    chk("frame_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    tx_point     = 1'b0;
    sample_point = 1'b0;
    sampled_rx   = 1'b1;
    bus_idle     = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    id           = '0;
    rtr          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({won, lost, err}), 32'd0);
    reset = 1'b0;
    idle(2);

    // case 1: all-dominant ID, two stuff bits
    start_frame(11'h000, 1'b0);
    chk("c1_model_seq", pack_seq(), 32'b000001000001000);
    run_rest(1'b0);
    chk("c1_tx_seq", pack_cap(16), 32'b0000010000010001);
    chk("c1_won", 32'(won_seen - w0), 32'd1);

    // case 2: lost at the 2nd ID bit
    force_pos = 2;
    force_val = 1'b0;
    start_frame(11'h7FF, 1'b1);
    run_rest(1'b0);
    force_pos = -1;
    chk("c2_tx_seq", pack_cap(3), 32'b011);
    chk("c2_lost", 32'(lost_seen - l0), 32'd1);
    chk("c2_won", 32'(won_seen - w0), 32'd0);

    // case 3: recessive read back during SOF
    force_pos = 0;
    force_val = 1'b1;
    start_frame(11'h123, 1'b0);
    run_rest(1'b0);
    force_pos = -1;
    chk("c3_err", 32'(err_seen - e0), 32'd1);
    chk("c3_won", 32'(won_seen - w0), 32'd0);

    // case 4: start held while bus busy
    id       = 11'h0F0;
    rtr      = 1'b1;
    start    = 1'b1;
    bus_idle = 1'b0;
    for (int b = 0; b < 10; b++) do_bit(1'b0);
    chk("c4_busy_held", 32'(busy), 32'd0);
    start_frame(11'h0F0, 1'b1);
    chk("c4_busy", 32'(busy), 32'd1);
    step(1'b1, 1'b0);
    chk("c4_sof", 32'(tx), 32'd0);
    idle(2);
    step(1'b0, 1'b1);
    idle(2);
    run_rest(1'b0);
    chk("c4_won", 32'(won_seen - w0), 32'd1);

    // case 5: coincident tx_point and sample_point
    start_frame(11'h555, 1'b0);
    chk("c5_model_seq", pack_seq(), 32'b0101010101010);
    run_rest(1'b1);
    chk("c5_tx_seq", pack_cap(14), 32'b01010101010101);
    chk("c5_won", 32'(won_seen - w0), 32'd1);

    // abort mid-frame: no pulse
    start_frame(11'h0AA, 1'b0);
    for (int b = 0; b < 3; b++) do_bit(1'b0);
    abort = 1'b1;
    step(1'b0, 1'b0);
    abort = 1'b0;
    run_rest(1'b0);
    chk("abort_pulses",
        32'((won_seen - w0) + (lost_seen - l0) + (err_seen - e0)), 32'd0);

    // case 6: asynchronous reset at the 6th bit
    start_frame(11'h000, 1'b0);
    for (int b = 0; b < 20 && m_pos < 6; b++) do_bit(1'b0);
    #2;
    reset    = 1'b1;
    m_busy   = 1'b0;
    exp_tx   = 1'b1;
    exp_busy = 1'b0;
    exp_won  = 1'b0;
    exp_lost = 1'b0;
    exp_err  = 1'b0;
    #1;
    chk("c6_tx_async", 32'(tx), 32'd1);
    chk("c6_outs", 32'({busy, won, lost, err}), 32'd0);
    idle(2);
    reset = 1'b0;
    idle(1);
    start_frame(11'h000, 1'b0);
    run_rest(1'b0);
    chk("c6_tx_seq", pack_cap(16), 32'b0000010000010001);
    chk("c6_won", 32'(won_seen - w0), 32'd1);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
